// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester round-robin front end for the shared multi-cycle
// CPU ALU. Accepts one op at a time, holds its operands on the ALU for a full
// cycle, captures the result and strobes it back to the requester that owns it.
//
// state | meaning
// IDLE  | no op in flight, ready to accept
// EXEC  | operands on the ALU, result settling
// RESP  | result registered, owner strobed, may accept the next op
module alu_arbiter #(
    parameter int WIDTH = 32,
    parameter int OPW   = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid_0,
    input  logic             req_valid_1,
    output logic             req_ready_0,
    output logic             req_ready_1,
    input  logic [WIDTH-1:0] req_a_0,
    input  logic [WIDTH-1:0] req_b_0,
    input  logic [WIDTH-1:0] req_a_1,
    input  logic [WIDTH-1:0] req_b_1,
    input  logic [OPW-1:0]   req_op_0,
    input  logic [OPW-1:0]   req_op_1,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OPW-1:0]   alu_op,
    input  logic [WIDTH-1:0] alu_c,
    input  logic             alu_zero,
    output logic             rsp_valid_0,
    output logic             rsp_valid_1,
    output logic [WIDTH-1:0] rsp_c,
    output logic             rsp_zero,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             prio;
    logic             winner;
    logic             can_accept;
    logic             accept;
    logic             owner;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [OPW-1:0]   op_q;
    logic [WIDTH-1:0] c_q;
    logic             zero_q;

    // Pick the winner: a lone valid wins outright, a tie goes to prio.
    // With nothing valid the winner is just prio; no accept can happen then.
    always_comb begin
        winner = prio;
        if (req_valid_0 && !req_valid_1) begin
            winner = 1'b0;
        end else if (req_valid_1 && !req_valid_0) begin
            winner = 1'b1;
        end
        can_accept = (state == IDLE) || (state == RESP);
        accept     = can_accept && (winner ? req_valid_1 : req_valid_0);
    end

    // Next-state and decoded outputs.
    always_comb begin
        state_nxt   = state;
        req_ready_0 = 1'b0;
        req_ready_1 = 1'b0;
        rsp_valid_0 = 1'b0;
        rsp_valid_1 = 1'b0;
        busy        = 1'b0;
        case (state)
            IDLE: begin
                req_ready_0 = !winner;
                req_ready_1 = winner;
                if (accept) begin
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                busy      = 1'b1;
                state_nxt = RESP;
            end
            RESP: begin
                req_ready_0 = !winner;
                req_ready_1 = winner;
                rsp_valid_0 = !owner;
                rsp_valid_1 = owner;
                state_nxt   = accept ? EXEC : IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Register the winner's operands and flip priority to the loser on accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            op_q  <= '0;
            owner <= 1'b0;
            prio  <= 1'b0;
        end else if (accept) begin
            a_q   <= winner ? req_a_1  : req_a_0;
            b_q   <= winner ? req_b_1  : req_b_0;
            op_q  <= winner ? req_op_1 : req_op_0;
            owner <= winner;
            prio  <= !winner;
        end
    end

    // Capture the ALU result at the end of EXEC; it holds until the next op.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_q    <= '0;
            zero_q <= 1'b0;
        end else if (state == EXEC) begin
            c_q    <= alu_c;
            zero_q <= alu_zero;
        end
    end

    assign alu_a    = a_q;
    assign alu_b    = b_q;
    assign alu_op   = op_q;
    assign rsp_c    = c_q;
    assign rsp_zero = zero_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter: a behavioural ALU hangs off the alu_* ports, a
// request model predicts grants and results into a queue, and a separate
// monitor pops and compares whenever the block strobes a response.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid_0, req_valid_1;
    logic        req_ready_0, req_ready_1;
    logic [31:0] req_a_0, req_b_0, req_a_1, req_b_1;
    logic [2:0]  req_op_0, req_op_1;
    logic [31:0] alu_a, alu_b, alu_c;
    logic [2:0]  alu_op;
    logic        alu_zero;
    logic        rsp_valid_0, rsp_valid_1;
    logic [31:0] rsp_c;
    logic        rsp_zero;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic        owner;
        logic [31:0] c;
        logic        z;
        int          due;
    } exp_t;

    exp_t exp_q[$];
    logic grant_log[$];

    // model state
    logic prio_m = 1'b0;
    logic exec_m = 1'b0;
    logic acc0_m = 1'b0;
    logic acc1_m = 1'b0;
    logic win_m;
    logic acc_m;

    // monitor state
    logic [31:0] last_c = '0;
    logic        last_z = 1'b0;
    exp_t        cur;

    logic [2:0] ops [5] = '{3'b000, 3'b001, 3'b010, 3'b110, 3'b111};

    alu_arbiter #(.WIDTH(32), .OPW(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_0(req_valid_0), .req_valid_1(req_valid_1),
        .req_ready_0(req_ready_0), .req_ready_1(req_ready_1),
        .req_a_0(req_a_0), .req_b_0(req_b_0),
        .req_a_1(req_a_1), .req_b_1(req_b_1),
        .req_op_0(req_op_0), .req_op_1(req_op_1),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_c(alu_c), .alu_zero(alu_zero),
        .rsp_valid_0(rsp_valid_0), .rsp_valid_1(rsp_valid_1),
        .rsp_c(rsp_c), .rsp_zero(rsp_zero), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] op);
        case (op)
            3'b000:  return a & b;
            3'b001:  return a | b;
            3'b010:  return a + b;
            3'b110:  return a - b;
            3'b111:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    // combinational ALU seen by the block
    assign alu_c    = alu_ref(alu_a, alu_b, alu_op);
    assign alu_zero = (alu_c == 32'd0);

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h expected %0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Request model: predicts busy/ready each cycle and queues the expected response.
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            prio_m = 1'b0;
            exec_m = 1'b0;
            acc0_m = 1'b0;
            acc1_m = 1'b0;
        end else begin
            win_m = (req_valid_0 && req_valid_1) ? prio_m : req_valid_1;
            acc_m = !exec_m && (req_valid_0 || req_valid_1);
            chk("busy", 64'(busy), 64'(exec_m));
            if (exec_m)
                chk("ready_in_exec", 64'({req_ready_1, req_ready_0}), 64'(0));
            else if (req_valid_0 || req_valid_1)
                chk("ready_grant", 64'({req_ready_1, req_ready_0}), win_m ? 64'(2) : 64'(1));
            acc0_m = acc_m && !win_m;
            acc1_m = acc_m && win_m;
            if (acc_m) begin
                cur.owner = win_m;
                cur.c     = win_m ? alu_ref(req_a_1, req_b_1, req_op_1)
                                  : alu_ref(req_a_0, req_b_0, req_op_0);
                cur.z     = (cur.c == 32'd0);
                cur.due   = cyc + 2;
                exp_q.push_back(cur);
                grant_log.push_back(req_ready_1);
                prio_m = !win_m;
            end
            exec_m = acc_m;
        end
    end

    // Monitor: compares each response strobe with the head of the queue.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (!rst_n) begin
            exp_q.delete();
            last_c = '0;
            last_z = 1'b0;
            chk("rst_rsp_valid", 64'({rsp_valid_1, rsp_valid_0}), 64'(0));
        end else if (rsp_valid_0 || rsp_valid_1) begin
            if (exp_q.size() == 0) begin
                chk("rsp_unexpected", 64'({rsp_valid_1, rsp_valid_0}), 64'(0));
            end else begin
                e = exp_q.pop_front();
                chk("rsp_cycle", 64'(cyc), 64'(e.due));
                chk("rsp_owner", 64'({rsp_valid_1, rsp_valid_0}), e.owner ? 64'(2) : 64'(1));
                chk("rsp_c", 64'(rsp_c), 64'(e.c));
                chk("rsp_zero", 64'(rsp_zero), 64'(e.z));
                last_c = e.c;
                last_z = e.z;
            end
        end else begin
            if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                chk("rsp_missing", 64'({rsp_valid_1, rsp_valid_0}),
                    exp_q[0].owner ? 64'(2) : 64'(1));
                void'(exp_q.pop_front());
            end
            chk("rsp_hold_c", 64'(rsp_c), 64'(last_c));
            chk("rsp_hold_zero", 64'(rsp_zero), 64'(last_z));
        end
    end

    task automatic issue(input logic who, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] op);
        bit got;
        got = 1'b0;
        if (who) begin
            req_a_1 = a; req_b_1 = b; req_op_1 = op; req_valid_1 = 1'b1;
        end else begin
            req_a_0 = a; req_b_0 = b; req_op_0 = op; req_valid_0 = 1'b1;
        end
        for (int n = 0; n < 10 && !got; n++) begin
            tick();
            got = who ? acc1_m : acc0_m;
        end
        chk("issue_accept_timeout", 64'(got), 64'(1));
        if (who) req_valid_1 = 1'b0;
        else     req_valid_0 = 1'b0;
    endtask

    // Stimulus.
    initial begin
        logic pend0, pend1;
        int   n_acc, n_tick;
        rst_n = 1'b0;
        req_valid_0 = 1'b0; req_valid_1 = 1'b0;
        req_a_0 = '0; req_b_0 = '0; req_op_0 = '0;
        req_a_1 = '0; req_b_1 = '0; req_op_1 = '0;
        repeat (3) tick();
        chk("reset_busy", 64'(busy), 64'(0));
        chk("reset_alu_op", 64'(alu_op), 64'(0));
        chk("reset_rsp_c", 64'(rsp_c), 64'(0));
        rst_n = 1'b1;
        tick();

        // single op on requester 0, then a zero result on requester 1
        issue(1'b0, 32'd5, 32'd3, 3'b010);
        repeat (4) tick();
        issue(1'b1, 32'd7, 32'd7, 3'b110);
        repeat (5) tick();

        // tie from reset: grants must alternate 0,1,0,1
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        grant_log.delete();
        req_a_0 = 32'd1;  req_b_0 = 32'd1; req_op_0 = 3'b010;
        req_a_1 = 32'd10; req_b_1 = 32'd4; req_op_1 = 3'b110;
        req_valid_0 = 1'b1; req_valid_1 = 1'b1;
        for (int n = 0; n < 30 && grant_log.size() < 4; n++) tick();
        req_valid_0 = 1'b0; req_valid_1 = 1'b0;
        chk("tie_grant_count", 64'(grant_log.size()), 64'(4));
        if (grant_log.size() >= 4)
            chk("tie_grant_order",
                64'({grant_log[3], grant_log[2], grant_log[1], grant_log[0]}), 64'(4'b1010));
        repeat (4) tick();

        // back-to-back on requester 1: one accept every other cycle
        n_acc = 0; n_tick = 0;
        req_a_1 = $urandom; req_b_1 = $urandom; req_op_1 = 3'b001;
        req_valid_1 = 1'b1;
        while (n_acc < 6 && n_tick < 30) begin
            tick();
            n_tick++;
            if (acc1_m) begin
                n_acc++;
                req_a_1 = $urandom; req_b_1 = $urandom;
            end
        end
        req_valid_1 = 1'b0;
        chk("b2b_accepts", 64'(n_acc), 64'(6));
        chk("b2b_cycles", 64'(n_tick), 64'(11));
        repeat (3) tick();

        // reset during EXEC aborts the op immediately
        issue(1'b0, 32'hFFFF_0000, 32'h0F0F_0F0F, 3'b001);
        chk("pre_reset_busy", 64'(busy), 64'(1));
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 64'(busy), 64'(0));
        chk("abort_alu_a", 64'(alu_a), 64'(0));
        chk("abort_alu_b", 64'(alu_b), 64'(0));
        chk("abort_alu_op", 64'(alu_op), 64'(0));
        chk("abort_rsp_c", 64'(rsp_c), 64'(0));
        chk("abort_rsp_zero", 64'(rsp_zero), 64'(0));
        chk("abort_rsp_valid", 64'({rsp_valid_1, rsp_valid_0}), 64'(0));
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        grant_log.delete();
        req_a_0 = 32'd2; req_b_0 = 32'd9; req_op_0 = 3'b111;
        req_a_1 = 32'd3; req_b_1 = 32'd3; req_op_1 = 3'b000;
        req_valid_0 = 1'b1; req_valid_1 = 1'b1;
        tick();
        req_valid_0 = 1'b0; req_valid_1 = 1'b0;
        chk("post_abort_grant_count", 64'(grant_log.size()), 64'(1));
        if (grant_log.size() >= 1)
            chk("post_abort_tie_winner", 64'(grant_log[0]), 64'(0));
        repeat (4) tick();

        // random traffic; requests are held until accepted
        pend0 = 1'b0; pend1 = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (acc0_m) pend0 = 1'b0;
            if (acc1_m) pend1 = 1'b0;
            if (!pend0 && $urandom_range(0, 2) == 0) begin
                pend0 = 1'b1;
                req_a_0 = $urandom;
                req_b_0 = ($urandom_range(0, 3) == 0) ? req_a_0 : $urandom;
                req_op_0 = ops[$urandom_range(0, 4)];
            end
            if (!pend1 && $urandom_range(0, 2) == 0) begin
                pend1 = 1'b1;
                req_a_1 = $urandom;
                req_b_1 = ($urandom_range(0, 3) == 0) ? req_a_1 : $urandom;
                req_op_1 = ops[$urandom_range(0, 4)];
            end
            req_valid_0 = pend0;
            req_valid_1 = pend1;
            tick();
        end
        req_valid_0 = 1'b0; req_valid_1 = 1'b0;
        repeat (6) tick();
        chk("queue_drained", 64'(exp_q.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Round-robin arbiter and sequencer that shares the single multi-cycle CPU ALU (`ALUSCPU`: 32-bit A/B, 3-bit op, C/zero outputs) between two requesters. Requester 0 is the execute stage; requester 1 is the PC/branch-target unit. The block accepts one operation at a time over a valid/ready handshake and registers the operands. It drives the ALU from those registers, captures C and zero, and returns them to the winning requester with a one-cycle response strobe.

## Interface
- `WIDTH`, 32, operand/result width
- `OPW`, 3, ALU op width (MIPS encoding: 000 and, 001 or, 010 add, 110 sub, 111 slt)

- `clk` in 1: single clock, rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `req_valid_0` / `req_valid_1` in 1: request present
- `req_ready_0` / `req_ready_1` out 1: request accepted this cycle when valid & ready
- `req_a_0`, `req_b_0`, `req_a_1`, `req_b_1` in WIDTH: operands
- `req_op_0`, `req_op_1` in OPW: ALU op
- `alu_a`, `alu_b` out WIDTH: to ALU A/B
- `alu_op` out OPW: to ALU op
- `alu_c` in WIDTH: from ALU C, combinational
- `alu_zero` in 1: from ALU zero
- `rsp_valid_0` / `rsp_valid_1` out 1: one-cycle result strobe per requester
- `rsp_c` out WIDTH: shared result bus
- `rsp_zero` out 1: shared zero flag
- `busy` out 1: high in EXEC

## Operation
- FSM states and transitions:
  - IDLE: go to EXEC on accept, otherwise stay in IDLE.
  - EXEC: always go to RESP.
  - RESP: go to EXEC on accept, otherwise go to IDLE.
- Acceptance is possible only in IDLE and RESP. No accept occurs in EXEC; both `req_ready_*` are 0 there.
- Arbitration uses a 1-bit pointer `prio`.
  - If only one valid is high, that requester wins.
  - If both are high, the requester indexed by `prio` wins.
  - After every accept, `prio` is set to the non-winner.
  - `prio` resets to 0, so requester 0 wins the first tie.
- `req_ready_i` = (state is IDLE or RESP) & winner == i. It may depend combinationally on `req_valid_*`. At most one ready is high per cycle.
- On accept, the block registers `a`, `b`, `op` and an owner id (0/1) from the winner.
- `alu_a`, `alu_b`, `alu_op` always equal the operand registers. The `op` code passes through unchanged; illegal codes are the ALU's concern.
- At the end of EXEC, the block registers `alu_c` into `rsp_c` and `alu_zero` into `rsp_zero`.
- In RESP, `rsp_valid_<owner>` = 1 for exactly one cycle. There is no response backpressure; requesters must sample it.
- `rsp_c` and `rsp_zero` hold their value until the next capture.
- Each requester has at most one outstanding op. A requester may re-request in the same RESP cycle that delivers its result.
- Reset values: state IDLE, `prio` 0, operand registers 0 (`alu_op` = 000), owner 0, `rsp_c` 0, `rsp_zero` 0, all `rsp_valid` 0, `busy` 0.
- Reset asserted mid-operation (EXEC or RESP) aborts the op. No `rsp_valid` is produced for it, and all outputs return to reset values immediately (asynchronously).

## Timing
- Accept at rising edge N (valid & ready high in cycle N-1):
  - EXEC during cycle N, with ALU inputs stable for the whole cycle.
  - Capture at edge N+1.
  - `rsp_valid` high during cycle N+1.
- Latency is 2 cycles from accept edge to the response cycle.
- Back-to-back throughput is one op per 2 cycles, because accepts in RESP overlap the response.
- The ALU must settle within one clock period. The block inserts no extra wait states.
- `busy` = (state == EXEC).

## Test plan
- Single op: req0 A=5, B=3, op=010 in IDLE.
  - `req_ready_0`=1 that cycle.
  - `busy` next cycle.
  - Following cycle: `rsp_valid_0`=1, `rsp_c`=8, `rsp_zero`=0, `rsp_valid_1`=0.
- Zero flag: req1 A=7, B=7, op=110.
  - `rsp_valid_1`=1, `rsp_c`=0, `rsp_zero`=1.
  - `rsp_c` holds 0 in later idle cycles.
- Tie after reset: both valid continuously, req0 (A=1, B=1, op=010), req1 (A=10, B=4, op=110).
  - Grants are 0,1,0,1.
  - Responses alternate: `rsp_c` = 2, 6, 2, 6, on cycles 2, 4, 6, 8 after the first accept.
- Back-to-back single requester: req1 valid continuously, op=001 (or).
  - `req_ready_1` is high every RESP cycle.
  - `rsp_valid_1` pulses every 2nd cycle.
  - `req_ready_1`=0 during every EXEC.
- Reset mid-EXEC: accept req0, pull `rst_n` low during EXEC for 1 cycle.
  - `busy`, `alu_*` and `rsp_*` go to 0 immediately.
  - No `rsp_valid_0` follows.
  - After release, the next tie is granted to requester 0.
